router_sync: RTL and testbench

Synchronizer between the router's packet-control FSM and the three output FIFOs. It latches the destination address at packet start and steers the FSM's single write strobe to the addressed FIFO. It muxes that FIFO's full flag back to the FSM, publishes per-port valid flags, and runs one watchdog timer per output port. The watchdog issues a one-cycle soft reset to a FIFO whose data sits unread for `TIMEOUT` consecutive cycles.

---
 rtl/router_pkg.sv | 15 +
 rtl/router_sr_timer.sv | 49 ++++
 rtl/router_sync.sv | 97 +++++++++
 tb/tb_router_sync.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router synchronizer: destination address
// encodings and the default watchdog sizing.
package router_pkg;

    typedef enum logic [1:0] {
        ADDR_P0   = 2'd0,
        ADDR_P1   = 2'd1,
        ADDR_P2   = 2'd2,
        ADDR_NONE = 2'd3
    } addr_e;

    localparam int TIMEOUT_DEF = 30;
    localparam int TW_DEF      = 5;

endpackage

// File: rtl/router_sr_timer.sv
// One per-port watchdog: emits a one-cycle soft reset after TIMEOUT
// consecutive cycles of valid data with no read.
module router_sr_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TW      = TW_DEF
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          sr_q, sr_d;
    logic          stall;

    assign stall = vld & ~rd;

    // The pulse cycle itself is never counted, so back-to-back pulses are TIMEOUT+1 apart.
    always_comb begin
        cnt_d = '0;
        sr_d  = 1'b0;
        if (!sr_q && stall) begin
            if (cnt_q == LAST) begin
                sr_d = 1'b1;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            sr_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    assign soft_reset = sr_q;

endmodule

// File: rtl/router_sync.sv
// Router synchronizer: latches the header address, steers the FSM write
// strobe and full flag, and hosts one watchdog per output FIFO.
module router_sync
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TW      = TW_DEF
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    addr_e addr_q, addr_d;

    assign addr_d = detect_add ? addr_e'(data_in) : addr_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q <= ADDR_NONE;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Decode uses the registered address, so a same-cycle header still writes the old port.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr_q)
            ADDR_P0: begin
                write_enb[0] = write_enb_reg;
                fifo_full    = full_0;
            end
            ADDR_P1: begin
                write_enb[1] = write_enb_reg;
                fifo_full    = full_1;
            end
            ADDR_P2: begin
                write_enb[2] = write_enb_reg;
                fifo_full    = full_2;
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    assign vld_out_0 = ~empty_0;
    assign vld_out_1 = ~empty_1;
    assign vld_out_2 = ~empty_2;

    router_sr_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_wd0 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (vld_out_0),
        .rd         (read_enb_0),
        .soft_reset (soft_reset_0)
    );

    router_sr_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_wd1 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (vld_out_1),
        .rd         (read_enb_1),
        .soft_reset (soft_reset_1)
    );

    router_sr_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_wd2 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (vld_out_2),
        .rd         (read_enb_2),
        .soft_reset (soft_reset_2)
    );

endmodule

// File: tb/tb_router_sync.sv
// Scoreboard bench for router_sync: stimulus queues expected steering
// samples and soft-reset pulses; monitors pop and compare on the falling edge.
module tb_router_sync;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       detect_add = 1'b0;
    logic [1:0] data_in = 2'b00;
    logic       write_enb_reg = 1'b0;
    logic       read_enb_0 = 1'b0, read_enb_1 = 1'b0, read_enb_2 = 1'b0;
    logic       empty_0 = 1'b1, empty_1 = 1'b1, empty_2 = 1'b1;
    logic       full_0 = 1'b0, full_1 = 1'b0, full_2 = 1'b0;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [2:0] we;
        logic       ff;
        logic [2:0] vld;
        logic [2:0] sr;
    } comb_t;

    typedef struct packed {
        int         at;
        logic [2:0] mask;
    } pulse_t;

    comb_t  comb_q[$];
    string  comb_name_q[$];
    pulse_t pulse_q[$];

    router_sync #(.TIMEOUT(30), .TW(5)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .read_enb_0    (read_enb_0),
        .read_enb_1    (read_enb_1),
        .read_enb_2    (read_enb_2),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .empty_2       (empty_2),
        .full_0        (full_0),
        .full_1        (full_1),
        .full_2        (full_2),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out_0     (vld_out_0),
        .vld_out_1     (vld_out_1),
        .vld_out_2     (vld_out_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Steering/flag monitor
    always @(negedge clock) begin
        if (comb_q.size() > 0) begin
            comb_t e;
            comb_t a;
            string n;
            e = comb_q.pop_front();
            n = comb_name_q.pop_front();
            a = '{we: write_enb, ff: fifo_full,
                  vld: {vld_out_2, vld_out_1, vld_out_0},
                  sr: {soft_reset_2, soft_reset_1, soft_reset_0}};
            check(n, int'(a), int'(e));
        end
    end

    // Soft-reset pulse monitor
    always @(negedge clock) begin
        logic [2:0] sr;
        sr = {soft_reset_2, soft_reset_1, soft_reset_0};
        if (sr != 3'b000) begin
            if (pulse_q.size() == 0) begin
                check("unexpected_pulse", int'(sr), 0);
            end else begin
                pulse_t p;
                p = pulse_q.pop_front();
                check("pulse_cycle", cyc, p.at);
                check("pulse_mask", int'(sr), int'(p.mask));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_comb(input string name, input logic [2:0] we, input logic ff,
                               input logic [2:0] vld);
        comb_q.push_back('{we: we, ff: ff, vld: vld, sr: 3'b000});
        comb_name_q.push_back(name);
        tick();
    endtask

    task automatic latch_addr(input logic [1:0] a);
        detect_add    = 1'b1;
        data_in       = a;
        write_enb_reg = 1'b0;
        tick();
        detect_add    = 1'b0;
    endtask

    initial begin
        int c0;

        // Reset: outputs forced quiet, valids still follow empties
        full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
        empty_1 = 1'b0;
        write_enb_reg = 1'b1;
        detect_add = 1'b1; data_in = 2'b01;
        tick();
        expect_comb("reset_outputs", 3'b000, 1'b0, 3'b010);
        empty_1 = 1'b1; empty_2 = 1'b0;
        expect_comb("reset_vld_track", 3'b000, 1'b0, 3'b100);
        empty_2 = 1'b1;
        detect_add = 1'b0; write_enb_reg = 1'b0;
        resetn = 1'b1;
        tick();
        write_enb_reg = 1'b1;
        expect_comb("after_reset_none", 3'b000, 1'b0, 3'b000);

        // Address steering
        latch_addr(2'b01);
        write_enb_reg = 1'b1;
        full_0 = 1'b0; full_1 = 1'b1; full_2 = 1'b0;
        expect_comb("steer_p1_full", 3'b010, 1'b1, 3'b000);
        full_0 = 1'b1; full_1 = 1'b0; full_2 = 1'b1;
        expect_comb("steer_p1_notfull", 3'b010, 1'b0, 3'b000);
        write_enb_reg = 1'b0;
        expect_comb("steer_p1_nowrite", 3'b000, 1'b0, 3'b000);

        latch_addr(2'b00);
        write_enb_reg = 1'b1;
        full_0 = 1'b1; full_1 = 1'b0; full_2 = 1'b0;
        expect_comb("steer_p0", 3'b001, 1'b1, 3'b000);

        latch_addr(2'b10);
        write_enb_reg = 1'b1;
        full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b0;
        expect_comb("steer_p2", 3'b100, 1'b0, 3'b000);

        latch_addr(2'b11);
        write_enb_reg = 1'b1;
        full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
        expect_comb("steer_none", 3'b000, 1'b0, 3'b000);

        // Same-cycle header and write: old address used first
        latch_addr(2'b10);
        full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b1;
        detect_add = 1'b1; data_in = 2'b00; write_enb_reg = 1'b1;
        expect_comb("same_cycle_old", 3'b100, 1'b1, 3'b000);
        detect_add = 1'b0;
        expect_comb("same_cycle_new", 3'b001, 1'b0, 3'b000);
        write_enb_reg = 1'b0;
        full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

        // Timeout on port 0, stall held through two pulses
        c0 = cyc;
        empty_0 = 1'b0; read_enb_0 = 1'b0;
        pulse_q.push_back('{at: c0 + 30, mask: 3'b001});
        pulse_q.push_back('{at: c0 + 61, mask: 3'b001});
        repeat (65) tick();
        empty_0 = 1'b1;
        repeat (3) tick();

        // Read at stalled edge 30 rescues port 1
        c0 = cyc;
        empty_1 = 1'b0; read_enb_1 = 1'b0;
        repeat (29) tick();
        read_enb_1 = 1'b1;
        tick();
        read_enb_1 = 1'b0;
        pulse_q.push_back('{at: c0 + 60, mask: 3'b010});
        repeat (31) tick();
        empty_1 = 1'b1;
        repeat (3) tick();

        // Asynchronous reset mid-count
        c0 = cyc;
        empty_1 = 1'b0;
        repeat (20) tick();
        check("cnt_before_reset", int'(dut.u_wd1.cnt_q), 20);
        #2 resetn = 1'b0;
        #1;
        check("cnt_async_clear", int'(dut.u_wd1.cnt_q), 0);
        check("sr_async_clear", int'(soft_reset_1), 0);
        empty_1 = 1'b1;
        tick();
        resetn = 1'b1;
        repeat (40) tick();

        // Independent simultaneous watchdogs
        c0 = cyc;
        empty_0 = 1'b0; empty_2 = 1'b0;
        read_enb_0 = 1'b0; read_enb_2 = 1'b0;
        pulse_q.push_back('{at: c0 + 30, mask: 3'b101});
        repeat (31) tick();
        empty_0 = 1'b1; empty_2 = 1'b1;
        repeat (5) tick();

        check("pulses_outstanding", pulse_q.size(), 0);
        check("comb_outstanding", comb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
